// File: rtl/disp_src_sched.sv
// disp_src_sched: display source scheduler.
// Waits for pixel PLL lock and a number of warm-up frames, then grants one of
// three video sources to the display. A newly granted source is muted for one
// frame, keeps the display for at least HOLD_FRAMES frames, and is then
// re-arbitrated round-robin. All decisions are taken on frame_begin edges, so
// request changes inside a frame never disturb the picture.
//
// Ports:
//   clk_disp     in   pixel clock (only clock)
//   rst_n        in   asynchronous active-low reset
//   pll_locked   in   pixel PLL lock, synchronous to clk_disp
//   frame_begin  in   one-cycle pulse at the start of each frame
//   src_req[2:0] in   level request per video source
//   src_sel[1:0] out  index of the granted source (pixel mux select)
//   src_gnt[2:0] out  one-hot grant, 000 when nothing is granted
//   switch_pulse out  one-cycle pulse when the grant moves
//   out_en       out  pixel output enable (0 blanks RGB)
//   hdmi_oe      out  HDMI transmitter output enable
module disp_src_sched #(
  parameter int WARMUP_FRAMES = 2,
  parameter int HOLD_FRAMES   = 4
) (
  input  logic       clk_disp,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       frame_begin,
  input  logic [2:0] src_req,
  output logic [1:0] src_sel,
  output logic [2:0] src_gnt,
  output logic       switch_pulse,
  output logic       out_en,
  output logic       hdmi_oe
);

  localparam int WW = (WARMUP_FRAMES < 2) ? 1 : $clog2(WARMUP_FRAMES + 1);
  localparam int HW = (HOLD_FRAMES < 2) ? 1 : $clog2(HOLD_FRAMES + 1);
  localparam logic [WW-1:0] WARM_MAX = WW'(WARMUP_FRAMES);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_FRAMES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2,
    MUTE   = 2'd3
  } state_t;

  // One-hot grant vector for a source index; index 3 maps to no grant.
  function automatic logic [2:0] onehot(input logic [1:0] idx);
    logic [2:0] v;
    case (idx)
      2'd0:    v = 3'b001;
      2'd1:    v = 3'b010;
      2'd2:    v = 3'b100;
      default: v = 3'b000;
    endcase
    return v;
  endfunction

  // Round-robin pick starting after cur (cur+1, cur+2, cur, modulo 3).
  // Returns {found, index}. Passing cur=2 yields a lowest-index-first search.
  function automatic logic [2:0] rr_pick(input logic [1:0] cur,
                                         input logic [2:0] req);
    logic [2:0] r;
    logic [1:0] c;
    r = 3'b000;
    c = cur;
    for (int k = 0; k < 3; k++) begin
      c = (c >= 2'd2) ? 2'd0 : c + 2'd1;
      if (!r[2] && req[c]) begin
        r = {1'b1, c};
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  state_t          state_r, state_n;
  logic [WW-1:0]   warm_r, warm_n, warm_inc_s;
  logic [HW-1:0]   hold_r, hold_n, hold_inc_s;
  logic [1:0]      sel_r, sel_n;
  logic [2:0]      gnt_r, gnt_n;
  logic            pulse_r, pulse_n;
  logic            out_en_r, out_en_n;
  logic            hdmi_oe_r, hdmi_oe_n;
  logic [2:0]      rr_s, init_s;
  logic            arb_s;

  // Helper terms: saturating hold count, arbitration trigger and winners.
  always_comb begin
    warm_inc_s = warm_r + WW'(1);
    hold_inc_s = (hold_r >= HOLD_MAX) ? HOLD_MAX : hold_r + HW'(1);
    rr_s       = rr_pick(sel_r, src_req);
    init_s     = rr_pick(2'd2, src_req);
    // Re-arbitrate when the hold period is used up (counting this frame),
    // when the granted source dropped its request, or when nothing is granted.
    arb_s      = (hold_inc_s == HOLD_MAX) || ((src_req & gnt_r) == 3'b000) ||
                 (gnt_r == 3'b000);
  end

  // Next-state and next-output logic of the scheduler FSM.
  always_comb begin
    state_n = state_r;
    warm_n  = warm_r;
    hold_n  = hold_r;
    sel_n   = sel_r;
    gnt_n   = gnt_r;
    pulse_n = 1'b0;
    if (!pll_locked) begin
      // Loss of lock wins over everything, including a coincident frame_begin.
      state_n = IDLE;
      warm_n  = '0;
      hold_n  = '0;
      sel_n   = 2'd0;
      gnt_n   = 3'b000;
    end else begin
      case (state_r)
        IDLE: begin
          state_n = WARMUP;
          warm_n  = '0;
        end
        WARMUP: begin
          if (frame_begin) begin
            if (warm_inc_s == WARM_MAX) begin
              warm_n = WARM_MAX;
              hold_n = '0;
              if (init_s[2]) begin
                sel_n   = init_s[1:0];
                gnt_n   = onehot(init_s[1:0]);
                pulse_n = 1'b1;
                state_n = MUTE;
              end else begin
                gnt_n   = 3'b000;
                state_n = RUN;
              end
            end else begin
              warm_n = warm_inc_s;
            end
          end else begin
            warm_n = warm_r;
          end
        end
        MUTE: begin
          // Mute frame is over; the exit frame counts as the first held frame.
          if (frame_begin) begin
            state_n = RUN;
            hold_n  = HW'(1);
          end else begin
            state_n = MUTE;
          end
        end
        RUN: begin
          if (frame_begin) begin
            hold_n = hold_inc_s;
            if (arb_s) begin
              if (!rr_s[2]) begin
                gnt_n = 3'b000;
              end else if ((rr_s[1:0] != sel_r) || (gnt_r == 3'b000)) begin
                sel_n   = rr_s[1:0];
                gnt_n   = onehot(rr_s[1:0]);
                pulse_n = 1'b1;
                hold_n  = '0;
                state_n = MUTE;
              end else begin
                // Sole requester keeps the display with a saturated count.
                gnt_n = gnt_r;
              end
            end else begin
              gnt_n = gnt_r;
            end
          end else begin
            hold_n = hold_r;
          end
        end
        default: begin
          state_n = IDLE;
          warm_n  = '0;
          hold_n  = '0;
          sel_n   = 2'd0;
          gnt_n   = 3'b000;
        end
      endcase
    end
    out_en_n  = (state_n == RUN) && (gnt_n != 3'b000);
    hdmi_oe_n = (state_n == RUN) || (state_n == MUTE);
  end

  // State, counter and output registers.
  always_ff @(posedge clk_disp or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      warm_r    <= '0;
      hold_r    <= '0;
      sel_r     <= 2'd0;
      gnt_r     <= 3'b000;
      pulse_r   <= 1'b0;
      out_en_r  <= 1'b0;
      hdmi_oe_r <= 1'b0;
    end else begin
      state_r   <= state_n;
      warm_r    <= warm_n;
      hold_r    <= hold_n;
      sel_r     <= sel_n;
      gnt_r     <= gnt_n;
      pulse_r   <= pulse_n;
      out_en_r  <= out_en_n;
      hdmi_oe_r <= hdmi_oe_n;
    end
  end

  assign src_sel      = sel_r;
  assign src_gnt      = gnt_r;
  assign switch_pulse = pulse_r;
  assign out_en       = out_en_r;
  assign hdmi_oe      = hdmi_oe_r;

endmodule

// File: tb/tb_disp_src_sched.sv
// tb_disp_src_sched: directed bench for disp_src_sched. Each step drives one
// cycle of inputs, pushes the expected registered outputs to a scoreboard and
// pops/compares them one time unit after the following rising edge.
module tb_disp_src_sched;

  logic       clk_disp;
  logic       rst_n;
  logic       pll_locked;
  logic       frame_begin;
  logic [2:0] src_req;
  logic [1:0] src_sel;
  logic [2:0] src_gnt;
  logic       switch_pulse;
  logic       out_en;
  logic       hdmi_oe;

  logic [7:0] obs;
  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } item_t;

  item_t sb[$];

  disp_src_sched #(.WARMUP_FRAMES(2), .HOLD_FRAMES(4)) dut (
    .clk_disp    (clk_disp),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .frame_begin (frame_begin),
    .src_req     (src_req),
    .src_sel     (src_sel),
    .src_gnt     (src_gnt),
    .switch_pulse(switch_pulse),
    .out_en      (out_en),
    .hdmi_oe     (hdmi_oe)
  );

  assign obs = {src_sel, src_gnt, switch_pulse, out_en, hdmi_oe};

  initial clk_disp = 1'b0;
  always #5 clk_disp = ~clk_disp;

  // Pack expected outputs as {src_sel, src_gnt, switch_pulse, out_en, hdmi_oe}.
  function automatic logic [7:0] ev(input logic [1:0] sel, input logic [2:0] gnt,
                                    input logic sp, input logic oe, input logic hoe);
    return {sel, gnt, sp, oe, hoe};
  endfunction

  task automatic push_exp(input string tag, input logic [7:0] e);
    item_t it;
    it.tag = tag;
    it.exp = e;
    sb.push_back(it);
  endtask

  task automatic check_pop();
    item_t it;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed %b expected a queued entry", obs);
    end else begin
      it = sb.pop_front();
      assert (obs === it.exp) else begin
        errors++;
        $error("FAIL %s observed %b expected %b", it.tag, obs, it.exp);
      end
    end
  endtask

  task automatic step(input logic pll, input logic fb, input logic [2:0] req,
                      input logic [7:0] e, input string tag);
    @(negedge clk_disp);
    pll_locked  = pll;
    frame_begin = fb;
    src_req     = req;
    push_exp(tag, e);
    @(posedge clk_disp);
    #1;
    check_pop();
  endtask

  localparam logic [7:0] Z = 8'b0000_0000;

  initial begin
    rst_n       = 1'b0;
    pll_locked  = 1'b0;
    frame_begin = 1'b0;
    src_req     = 3'b000;
    repeat (2) @(posedge clk_disp);
    #1;
    push_exp("reset", Z);
    check_pop();

    @(negedge clk_disp);
    rst_n      = 1'b1;
    pll_locked = 1'b1;
    src_req    = 3'b010;

    // Lock, warm-up and initial grant to source 1.
    step(1'b1, 1'b0, 3'b010, Z, "idle_to_warm");
    step(1'b1, 1'b1, 3'b010, Z, "warm_1");
    step(1'b1, 1'b0, 3'b010, Z, "warm_gap");
    step(1'b1, 1'b1, 3'b010, ev(2'd1, 3'b010, 1'b1, 1'b0, 1'b1), "init_grant");
    step(1'b1, 1'b0, 3'b010, ev(2'd1, 3'b010, 1'b0, 1'b0, 1'b1), "pulse_clear");
    step(1'b1, 1'b0, 3'b111, ev(2'd1, 3'b010, 1'b0, 1'b0, 1'b1), "mute_req_change");
    step(1'b1, 1'b1, 3'b111, ev(2'd1, 3'b010, 1'b0, 1'b1, 1'b1), "run_enter");

    // All sources requesting: hold for four frames, then rotate 1 -> 2 -> 0.
    step(1'b1, 1'b1, 3'b111, ev(2'd1, 3'b010, 1'b0, 1'b1, 1'b1), "hold2");
    step(1'b1, 1'b0, 3'b111, ev(2'd1, 3'b010, 1'b0, 1'b1, 1'b1), "hold_gap");
    step(1'b1, 1'b1, 3'b111, ev(2'd1, 3'b010, 1'b0, 1'b1, 1'b1), "hold3");
    step(1'b1, 1'b1, 3'b111, ev(2'd2, 3'b100, 1'b1, 1'b0, 1'b1), "rr_to_2");
    step(1'b1, 1'b0, 3'b111, ev(2'd2, 3'b100, 1'b0, 1'b0, 1'b1), "mute_src2");
    step(1'b1, 1'b1, 3'b111, ev(2'd2, 3'b100, 1'b0, 1'b1, 1'b1), "run_src2");
    step(1'b1, 1'b1, 3'b111, ev(2'd2, 3'b100, 1'b0, 1'b1, 1'b1), "src2_h2");
    step(1'b1, 1'b1, 3'b111, ev(2'd2, 3'b100, 1'b0, 1'b1, 1'b1), "src2_h3");
    step(1'b1, 1'b1, 3'b111, ev(2'd0, 3'b001, 1'b1, 1'b0, 1'b1), "rr_wrap_0");
    step(1'b1, 1'b1, 3'b111, ev(2'd0, 3'b001, 1'b0, 1'b1, 1'b1), "run_src0");

    // Sole requester keeps the display past saturation without a pulse.
    step(1'b1, 1'b1, 3'b001, ev(2'd0, 3'b001, 1'b0, 1'b1, 1'b1), "sole_h2");
    step(1'b1, 1'b1, 3'b001, ev(2'd0, 3'b001, 1'b0, 1'b1, 1'b1), "sole_h3");
    step(1'b1, 1'b1, 3'b001, ev(2'd0, 3'b001, 1'b0, 1'b1, 1'b1), "sole_sat");
    step(1'b1, 1'b1, 3'b001, ev(2'd0, 3'b001, 1'b0, 1'b1, 1'b1), "sole_sat_again");

    // Granted source drops its request: switch at the next frame boundary.
    step(1'b1, 1'b1, 3'b100, ev(2'd2, 3'b100, 1'b1, 1'b0, 1'b1), "drop_to_2");
    step(1'b1, 1'b1, 3'b100, ev(2'd2, 3'b100, 1'b0, 1'b1, 1'b1), "run_src2_b");
    step(1'b1, 1'b0, 3'b001, ev(2'd2, 3'b100, 1'b0, 1'b1, 1'b1), "midframe_drop");
    step(1'b1, 1'b0, 3'b001, ev(2'd2, 3'b100, 1'b0, 1'b1, 1'b1), "midframe_hold");
    step(1'b1, 1'b1, 3'b001, ev(2'd0, 3'b001, 1'b1, 1'b0, 1'b1), "drop_switch");
    step(1'b1, 1'b0, 3'b001, ev(2'd0, 3'b001, 1'b0, 1'b0, 1'b1), "mute_after_drop");
    step(1'b1, 1'b1, 3'b001, ev(2'd0, 3'b001, 1'b0, 1'b1, 1'b1), "run_src0_b");

    // No requesters: blank, keep src_sel; regrant when a request appears.
    step(1'b1, 1'b1, 3'b000, ev(2'd0, 3'b000, 1'b0, 1'b0, 1'b1), "no_req");
    step(1'b1, 1'b0, 3'b100, ev(2'd0, 3'b000, 1'b0, 1'b0, 1'b1), "no_req_gap");
    step(1'b1, 1'b1, 3'b100, ev(2'd2, 3'b100, 1'b1, 1'b0, 1'b1), "regrant_2");
    step(1'b1, 1'b1, 3'b100, ev(2'd2, 3'b100, 1'b0, 1'b1, 1'b1), "regrant_run");

    // Lock loss coincident with frame_begin has priority.
    step(1'b0, 1'b1, 3'b111, Z, "pll_drop_fb");
    step(1'b0, 1'b0, 3'b111, Z, "pll_low");

    // Relock with no requesters: warm-up ends in RUN with nothing granted.
    step(1'b1, 1'b0, 3'b000, Z, "relock");
    step(1'b1, 1'b1, 3'b000, Z, "relock_w1");
    step(1'b1, 1'b1, 3'b000, ev(2'd0, 3'b000, 1'b0, 1'b0, 1'b1), "warm_no_req");
    step(1'b1, 1'b1, 3'b001, ev(2'd0, 3'b001, 1'b1, 1'b0, 1'b1), "grant_from_empty");
    step(1'b1, 1'b0, 3'b001, ev(2'd0, 3'b001, 1'b0, 1'b0, 1'b1), "mute_src0");

    // Asynchronous reset during MUTE, away from any clock edge.
    @(negedge clk_disp);
    #2;
    rst_n = 1'b0;
    #1;
    push_exp("async_reset", Z);
    check_pop();
    @(negedge clk_disp);
    rst_n = 1'b1;

    // Warm-up count must restart from zero after reset.
    step(1'b1, 1'b0, 3'b010, Z, "post_rst_idle");
    step(1'b1, 1'b1, 3'b010, Z, "rewarm_1");
    step(1'b1, 1'b1, 3'b010, ev(2'd1, 3'b010, 1'b1, 1'b0, 1'b1), "rewarm_grant");

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_leftover observed %0d expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
